// File: rtl/vga_text_console_writer.sv
// Avalon-MM writer turning a character stream into VGA text VRAM writes.
// Define VGA_CONSOLE_SCROLL_EN to scroll at the bottom row instead of wrapping.
module vga_text_console_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          CTRL_WORD  = 600,
  parameter logic [31:0] INIT_COLOR = 32'h01FF_E000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  CH_DATA,
  input  logic        CH_VALID,
  output logic        CH_READY,
  input  logic        CLEAR_REQ,
  output logic [9:0]  AVM_ADDR,
  output logic        AVM_WRITE,
  output logic        AVM_READ,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST,
  input  logic        AVM_READDATAVALID,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic        BUSY
);

  localparam int WORDS  = COLS * ROWS / 4;
  localparam int RWORDS = COLS / 4;

  typedef enum logic [2:0] {
    S_INIT,
    S_CLEAR,
    S_IDLE,
    S_PUT,
    S_ADV,
    S_CLR_ROW
`ifdef VGA_CONSOLE_SCROLL_EN
    , S_SCROLL
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [9:0]  addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  ch_q, ch_d;
  logic [11:0] pos;
  logic [9:0]  row_base;
  logic        wr_acc;
`ifdef VGA_CONSOLE_SCROLL_EN
  logic        rd_q, rd_d;
  logic [1:0]  sph_q, sph_d;
`else
  logic        unused_ok;
  assign unused_ok = ^{AVM_READDATA, AVM_READDATAVALID};
`endif

  assign pos      = {7'd0, row_q} * 12'(COLS) + {5'd0, col_q};
  assign row_base = {5'd0, row_q} * 10'(RWORDS);
  assign wr_acc   = wr_q & ~AVM_WAITREQUEST;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ch_d     = ch_q;
    CH_READY = 1'b0;
`ifdef VGA_CONSOLE_SCROLL_EN
    rd_d     = rd_q;
    sph_d    = sph_q;
`endif
    unique case (state_q)
      S_INIT: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = 10'(CTRL_WORD);
          be_d    = 4'hF;
          wdata_d = INIT_COLOR;
        end else if (wr_acc) begin
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = cnt_q;
          be_d    = 4'hF;
          wdata_d = '0;
        end else if (wr_acc) begin
          wr_d = 1'b0;
          if (cnt_q == 10'(WORDS - 1)) begin
            col_d   = '0;
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      S_IDLE: begin
        CH_READY = ~CLEAR_REQ;
        if (CLEAR_REQ) begin
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else if (CH_VALID) begin
          unique case (1'b1)
            CH_DATA == 8'h0A: begin
              col_d   = '0;
              state_d = S_ADV;
            end
            CH_DATA == 8'h0D: col_d = '0;
            CH_DATA == 8'h08: begin
              if (col_q != 7'd0) col_d = col_q - 7'd1;
            end
            default: begin
              ch_d    = CH_DATA;
              state_d = S_PUT;
            end
          endcase
        end
      end
      S_PUT: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = pos[11:2];
          be_d    = 4'b0001 << pos[1:0];
          wdata_d = {4{ch_q}};
        end else if (wr_acc) begin
          wr_d = 1'b0;
          if (col_q == 7'(COLS - 1)) begin
            col_d   = '0;
            state_d = S_ADV;
          end else begin
            col_d   = col_q + 7'd1;
            state_d = S_IDLE;
          end
        end
      end
      S_ADV: begin
        cnt_d = '0;
        if (row_q != 5'(ROWS - 1)) begin
          row_d   = row_q + 5'd1;
          state_d = S_CLR_ROW;
        end else begin
`ifdef VGA_CONSOLE_SCROLL_EN
          sph_d   = 2'd0;
          state_d = S_SCROLL;
`else
          row_d   = '0;
          state_d = S_CLR_ROW;
`endif
        end
      end
      S_CLR_ROW: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = row_base + cnt_q;
          be_d    = 4'hF;
          wdata_d = '0;
        end else if (wr_acc) begin
          wr_d = 1'b0;
          if (cnt_q == 10'(RWORDS - 1)) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
`ifdef VGA_CONSOLE_SCROLL_EN
      // read word i+RWORDS, then write it back to word i
      S_SCROLL: begin
        unique case (sph_q)
          2'd0: begin
            if (!rd_q) begin
              rd_d   = 1'b1;
              addr_d = cnt_q + 10'(RWORDS);
              be_d   = 4'hF;
            end else if (!AVM_WAITREQUEST) begin
              rd_d  = 1'b0;
              sph_d = 2'd1;
            end
          end
          2'd1: begin
            if (AVM_READDATAVALID) begin
              wr_d    = 1'b1;
              addr_d  = cnt_q;
              be_d    = 4'hF;
              wdata_d = AVM_READDATA;
              sph_d   = 2'd2;
            end
          end
          default: begin
            if (wr_acc) begin
              wr_d  = 1'b0;
              sph_d = 2'd0;
              if (cnt_q == 10'(WORDS - RWORDS - 1)) begin
                cnt_d   = '0;
                state_d = S_CLR_ROW;
              end else begin
                cnt_d = cnt_q + 10'd1;
              end
            end
          end
        endcase
      end
`endif
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_INIT;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ch_q    <= '0;
`ifdef VGA_CONSOLE_SCROLL_EN
      rd_q    <= 1'b0;
      sph_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ch_q    <= ch_d;
`ifdef VGA_CONSOLE_SCROLL_EN
      rd_q    <= rd_d;
      sph_q   <= sph_d;
`endif
    end
  end

  assign AVM_ADDR      = addr_q;
  assign AVM_WRITE     = wr_q;
  assign AVM_BYTE_EN   = be_q;
  assign AVM_WRITEDATA = wdata_q;
`ifdef VGA_CONSOLE_SCROLL_EN
  assign AVM_READ      = rd_q;
`else
  assign AVM_READ      = 1'b0;
`endif
  assign CURSOR_COL    = col_q;
  assign CURSOR_ROW    = row_q;
  assign BUSY          = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_text_console_writer.sv
// Scoreboard bench for vga_text_console_writer.
// Expected VRAM writes are queued as stimulus is driven.
module tb_vga_text_console_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  CH_DATA;
  logic        CH_VALID;
  logic        CH_READY;
  logic        CLEAR_REQ;
  logic [9:0]  AVM_ADDR;
  logic        AVM_WRITE;
  logic        AVM_READ;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic [31:0] AVM_READDATA = '0;
  logic        AVM_WAITREQUEST;
  logic        AVM_READDATAVALID = 1'b0;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic        BUSY;

  vga_text_console_writer dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .CH_DATA          (CH_DATA),
    .CH_VALID         (CH_VALID),
    .CH_READY         (CH_READY),
    .CLEAR_REQ        (CLEAR_REQ),
    .AVM_ADDR         (AVM_ADDR),
    .AVM_WRITE        (AVM_WRITE),
    .AVM_READ         (AVM_READ),
    .AVM_BYTE_EN      (AVM_BYTE_EN),
    .AVM_WRITEDATA    (AVM_WRITEDATA),
    .AVM_READDATA     (AVM_READDATA),
    .AVM_WAITREQUEST  (AVM_WAITREQUEST),
    .AVM_READDATAVALID(AVM_READDATAVALID),
    .CURSOR_COL       (CURSOR_COL),
    .CURSOR_ROW       (CURSOR_ROW),
    .BUSY             (BUSY)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_got;
  wr_t        mon_exp;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       rd_fire = 1'b0;
  logic [9:0] rd_addr = '0;

  function automatic logic [31:0] mem_val(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // Bus monitor + VRAM read responder (one-cycle read latency)
  always begin
    @(negedge CLK);
    rd_fire = 1'b0;
    if (AVM_WRITE === 1'b1 && AVM_WAITREQUEST === 1'b0) begin
      mon_got = {AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected got a=%0d be=%b d=%h required none",
                 mon_got.a, mon_got.be, mon_got.d);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL wr_scoreboard got a=%0d be=%b d=%h required a=%0d be=%b d=%h",
                   mon_got.a, mon_got.be, mon_got.d,
                   mon_exp.a, mon_exp.be, mon_exp.d);
        end
      end
    end
    if (AVM_READ === 1'b1 && AVM_WAITREQUEST === 1'b0) begin
      rd_fire = 1'b1;
      rd_addr = AVM_ADDR;
`ifndef VGA_CONSOLE_SCROLL_EN
      n_cmp++;
      n_bad++;
      $display("FAIL rd_unexpected got a=%0d required no read", AVM_ADDR);
`endif
    end
    @(posedge CLK);
    #1;
    AVM_READDATAVALID = rd_fire;
    AVM_READDATA      = rd_fire ? mem_val(rd_addr) : 32'd0;
  end

  task automatic push_w(input int a, input logic [3:0] be,
                        input logic [31:0] d);
    wr_t e;
    e = {10'(a), be, d};
    exp_q.push_back(e);
  endtask

  task automatic push_zeros(input int first, input int n);
    for (int i = 0; i < n; i++) push_w(first + i, 4'hF, 32'd0);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    while (k < limit) begin
      @(negedge CLK);
      if (BUSY === 1'b0) break;
      k++;
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle_timeout BUSY=%b required 0", name, BUSY);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    int k;
    CH_DATA  = c;
    CH_VALID = 1'b1;
    k = 0;
    @(negedge CLK);
    while (CH_READY !== 1'b1 && k < 5000) begin
      @(negedge CLK);
      k++;
    end
    n_cmp++;
    if (CH_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL send_timeout char=%h CH_READY=%b required 1", c, CH_READY);
    end
    @(posedge CLK);
    #1;
    CH_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET           = 1'b1;
    CH_VALID        = 1'b0;
    CH_DATA         = 8'h00;
    CLEAR_REQ       = 1'b0;
    AVM_WAITREQUEST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({AVM_WRITE, AVM_READ, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA,
         CH_READY, BUSY, CURSOR_COL, CURSOR_ROW} !==
        {1'b0, 1'b0, 4'h0, 10'd0, 32'd0, 1'b0, 1'b1, 7'd0, 5'd0}) begin
      n_bad++;
      $display("FAIL reset_state got wr=%b rd=%b be=%b a=%0d d=%h rdy=%b busy=%b cur=(%0d,%0d) required zeros busy=1",
               AVM_WRITE, AVM_READ, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA,
               CH_READY, BUSY, CURSOR_COL, CURSOR_ROW);
    end
    push_w(600, 4'hF, 32'h01FF_E000);
    push_zeros(0, 600);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    wait_idle("init", 5000);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW, 32'(exp_q.size())} !== {7'd0, 5'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL init_done got cur=(%0d,%0d) pending=%0d required (0,0) pending=0",
               CURSOR_COL, CURSOR_ROW, exp_q.size());
    end
  endtask

  task automatic test_put();
    push_w(0, 4'b0001, 32'h4141_4141);
    push_w(0, 4'b0010, 32'hC2C2_C2C2);
    send(8'h41);
    send(8'hC2);
    wait_idle("put", 100);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd2, 5'd0}) begin
      n_bad++;
      $display("FAIL put_cursor got (%0d,%0d) required (2,0)",
               CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_wrap();
    send(8'h0D);
    for (int r = 1; r <= 5; r++) begin
      push_zeros(r * 20, 20);
      send(8'h0A);
    end
    for (int i = 0; i < 78; i++) begin
      push_w((400 + i) / 4, 4'b0001 << ((400 + i) % 4), {4{8'(8'h30 + i)}});
      send(8'(8'h30 + i));
    end
    push_w(119, 4'b0100, 32'h4141_4141);
    push_w(119, 4'b1000, 32'h4242_4242);
    push_zeros(120, 20);
    send(8'h41);
    send(8'h42);
    wait_idle("wrap", 200);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd0, 5'd6}) begin
      n_bad++;
      $display("FAIL wrap_cursor got (%0d,%0d) required (0,6)",
               CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_ctrl_chars();
    push_w(120, 4'b0001, 32'h6161_6161);
    send(8'h61);
    send(8'h08);
    send(8'h08);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd0, 5'd6}) begin
      n_bad++;
      $display("FAIL bs_cursor got (%0d,%0d) required (0,6)",
               CURSOR_COL, CURSOR_ROW);
    end
    push_w(120, 4'b0001, 32'h6262_6262);
    push_w(120, 4'b0010, 32'h6363_6363);
    send(8'h62);
    send(8'h63);
    send(8'h0D);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW, BUSY} !== {7'd0, 5'd6, 1'b0}) begin
      n_bad++;
      $display("FAIL cr_cursor got (%0d,%0d) busy=%b required (0,6) busy=0",
               CURSOR_COL, CURSOR_ROW, BUSY);
    end
  endtask

  task automatic test_waitreq();
    push_w(120, 4'b0001, 32'h5555_5555);
    AVM_WAITREQUEST = 1'b1;
    send(8'h55);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA, CH_READY} !==
          {1'b1, 10'd120, 4'b0001, 32'h5555_5555, 1'b0}) begin
        n_bad++;
        $display("FAIL waitreq_hold cyc=%0d got wr=%b a=%0d be=%b d=%h rdy=%b required wr=1 a=120 be=0001 d=55555555 rdy=0",
                 i, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA, CH_READY);
      end
    end
    @(posedge CLK);
    #1;
    AVM_WAITREQUEST = 1'b0;
    wait_idle("waitreq", 100);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW, 32'(exp_q.size())} !== {7'd1, 5'd6, 32'd0}) begin
      n_bad++;
      $display("FAIL waitreq_done got (%0d,%0d) pending=%0d required (1,6) pending=0",
               CURSOR_COL, CURSOR_ROW, exp_q.size());
    end
  endtask

  task automatic test_clear();
    push_zeros(0, 600);
    CLEAR_REQ = 1'b1;
    CH_VALID  = 1'b1;
    CH_DATA   = 8'h5A;
    @(negedge CLK);
    n_cmp++;
    if (CH_READY !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_ready got %b required 0", CH_READY);
    end
    @(posedge CLK);
    #1;
    CLEAR_REQ = 1'b0;
    CH_VALID  = 1'b0;
    wait_idle("clear", 5000);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW, 32'(exp_q.size())} !== {7'd0, 5'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL clear_done got (%0d,%0d) pending=%0d required (0,0) pending=0",
               CURSOR_COL, CURSOR_ROW, exp_q.size());
    end
  endtask

  task automatic test_bottom();
    for (int r = 1; r <= 29; r++) begin
      push_zeros(r * 20, 20);
      send(8'h0A);
    end
    wait_idle("rows", 200);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd0, 5'd29}) begin
      n_bad++;
      $display("FAIL row29_cursor got (%0d,%0d) required (0,29)",
               CURSOR_COL, CURSOR_ROW);
    end
`ifdef VGA_CONSOLE_SCROLL_EN
    for (int i = 0; i < 580; i++) push_w(i, 4'hF, mem_val(10'(i + 20)));
    push_zeros(580, 20);
    send(8'h0A);
    wait_idle("scroll", 10000);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd0, 5'd29}) begin
      n_bad++;
      $display("FAIL scroll_cursor got (%0d,%0d) required (0,29)",
               CURSOR_COL, CURSOR_ROW);
    end
`else
    push_zeros(0, 20);
    send(8'h0A);
    wait_idle("bottom", 200);
    n_cmp++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd0, 5'd0}) begin
      n_bad++;
      $display("FAIL bottom_cursor got (%0d,%0d) required (0,0)",
               CURSOR_COL, CURSOR_ROW);
    end
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_pending got %0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_put();
    test_wrap();
    test_ctrl_chars();
    test_waitreq();
    test_clear();
    test_bottom();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
